// File: rtl/wb_commit_stage_if.sv
// Memory-to-writeback handshake and instruction payload bundle.
interface wb_commit_stage_if #(
  parameter int EXCP_W    = 16,
  parameter int CSR_IDX_W = 14
);
  logic                 ms_to_ws_valid;
  logic                 ws_allowin;
  logic [31:0]          ms_pc;
  logic [31:0]          ms_result;
  logic                 ms_gr_we;
  logic [4:0]           ms_dest;
  logic                 ms_excp;
  logic [EXCP_W-1:0]    ms_excp_num;
  logic [31:0]          ms_error_va;
  logic                 ms_ertn;
  logic                 ms_refetch;
  logic                 ms_idle;
  logic                 ms_csr_we;
  logic [CSR_IDX_W-1:0] ms_csr_idx;
  logic [31:0]          ms_csr_wdata;

  // memory stage side
  modport master (
    output ms_to_ws_valid, ms_pc, ms_result, ms_gr_we, ms_dest, ms_excp, ms_excp_num,
           ms_error_va, ms_ertn, ms_refetch, ms_idle, ms_csr_we, ms_csr_idx, ms_csr_wdata,
    input  ws_allowin
  );

  // writeback stage side
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_result, ms_gr_we, ms_dest, ms_excp, ms_excp_num,
           ms_error_va, ms_ertn, ms_refetch, ms_idle, ms_csr_we, ms_csr_idx, ms_csr_wdata,
    output ws_allowin
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Writeback stage: registers one retiring instruction, commits GPR/CSR writes,
// forwards to decode, raises flush pulses, parks the core on idle and counts retirements.
//
// state | meaning
// RUN   | normal operation, stage accepts instructions
// IDLE  | idle instruction committed, stage closed until an interrupt is pending
module wb_commit_stage #(
  parameter int EXCP_W    = 16,
  parameter int CSR_IDX_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_commit_stage_if.slave     ms_bus,
  input  logic                 has_int,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 ws_fwd_en,
  output logic [4:0]           ws_fwd_dest,
  output logic [31:0]          ws_fwd_data,
  output logic                 csr_we,
  output logic [CSR_IDX_W-1:0] csr_idx,
  output logic [31:0]          csr_wdata,
  output logic                 excp_flush,
  output logic                 ertn_flush,
  output logic                 refetch_flush,
  output logic                 idle_flush,
  output logic [31:0]          wb_pc,
  output logic [EXCP_W-1:0]    wb_excp_num,
  output logic [31:0]          wb_badv,
  output logic                 idle_lock,
  output logic [63:0]          inst_retired
);

  typedef enum logic {RUN = 1'b0, IDLE = 1'b1} state_t;

  state_t               state;
  logic                 ws_valid;
  logic                 ws_ready_go;
  logic                 any_flush;

  logic [31:0]          ws_pc;
  logic [31:0]          ws_result;
  logic                 ws_gr_we;
  logic [4:0]           ws_dest;
  logic                 ws_excp;
  logic [EXCP_W-1:0]    ws_excp_num;
  logic [31:0]          ws_error_va;
  logic                 ws_ertn;
  logic                 ws_refetch;
  logic                 ws_idle;
  logic                 ws_csr_we;
  logic [CSR_IDX_W-1:0] ws_csr_idx;
  logic [31:0]          ws_csr_wdata;

  assign ws_ready_go       = (state == RUN);
  assign ms_bus.ws_allowin = (state == RUN) && (!ws_valid || ws_ready_go);

  // Exception outranks ertn, which outranks refetch; idle only yields to exception.
  assign excp_flush    = ws_valid & ws_excp;
  assign ertn_flush    = ws_valid & ws_ertn & ~ws_excp;
  assign refetch_flush = ws_valid & ws_refetch & ~ws_excp & ~ws_ertn;
  assign idle_flush    = ws_valid & ws_idle & ~ws_excp;
  assign any_flush     = excp_flush | ertn_flush | refetch_flush | idle_flush;

  assign rf_we       = ws_valid & ws_gr_we & ~ws_excp & (ws_dest != 5'd0);
  assign rf_waddr    = ws_dest;
  assign rf_wdata    = ws_result;
  assign ws_fwd_en   = rf_we;
  assign ws_fwd_dest = ws_dest;
  assign ws_fwd_data = ws_result;

  assign csr_we    = ws_valid & ws_csr_we & ~ws_excp;
  assign csr_idx   = ws_csr_idx;
  assign csr_wdata = ws_csr_wdata;

  assign wb_pc       = ws_pc;
  assign wb_excp_num = ws_excp_num;
  assign wb_badv     = ws_error_va;

  // Stage valid bit: a flushing instruction also discards whatever arrives with it.
  always_ff @(posedge clk) begin
    if (reset || any_flush) begin
      ws_valid <= 1'b0;
    end else if (ms_bus.ws_allowin) begin
      ws_valid <= ms_bus.ms_to_ws_valid;
    end
  end

  // Payload register, loaded on every accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_pc        <= '0;
      ws_result    <= '0;
      ws_gr_we     <= 1'b0;
      ws_dest      <= '0;
      ws_excp      <= 1'b0;
      ws_excp_num  <= '0;
      ws_error_va  <= '0;
      ws_ertn      <= 1'b0;
      ws_refetch   <= 1'b0;
      ws_idle      <= 1'b0;
      ws_csr_we    <= 1'b0;
      ws_csr_idx   <= '0;
      ws_csr_wdata <= '0;
    end else if (ms_bus.ms_to_ws_valid && ms_bus.ws_allowin) begin
      ws_pc        <= ms_bus.ms_pc;
      ws_result    <= ms_bus.ms_result;
      ws_gr_we     <= ms_bus.ms_gr_we;
      ws_dest      <= ms_bus.ms_dest;
      ws_excp      <= ms_bus.ms_excp;
      ws_excp_num  <= ms_bus.ms_excp_num;
      ws_error_va  <= ms_bus.ms_error_va;
      ws_ertn      <= ms_bus.ms_ertn;
      ws_refetch   <= ms_bus.ms_refetch;
      ws_idle      <= ms_bus.ms_idle;
      ws_csr_we    <= ms_bus.ms_csr_we;
      ws_csr_idx   <= ms_bus.ms_csr_idx;
      ws_csr_wdata <= ms_bus.ms_csr_wdata;
    end
  end

  // Idle FSM; entering IDLE ignores has_int so the core always parks for at least one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      idle_lock <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (idle_flush) begin
            state     <= IDLE;
            idle_lock <= 1'b1;
          end
        end
        IDLE: begin
          if (has_int) begin
            state     <= RUN;
            idle_lock <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          idle_lock <= 1'b0;
        end
      endcase
    end
  end

  // Retired-instruction counter; excepting instructions do not count, wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_retired <= '0;
    end else if (ws_valid && !ws_excp) begin
      inst_retired <= inst_retired + 64'd1;
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_wb_commit_stage;
  logic clk = 1'b0;
  logic reset;
  logic has_int;
  always #5 clk = ~clk;

  wb_commit_stage_if #(.EXCP_W(16), .CSR_IDX_W(14)) bus ();

  logic        rf_we, ws_fwd_en, csr_we;
  logic [4:0]  rf_waddr, ws_fwd_dest;
  logic [31:0] rf_wdata, ws_fwd_data, csr_wdata, wb_pc, wb_badv;
  logic [13:0] csr_idx;
  logic [15:0] wb_excp_num;
  logic        excp_flush, ertn_flush, refetch_flush, idle_flush, idle_lock;
  logic [63:0] inst_retired;

  wb_commit_stage #(.EXCP_W(16), .CSR_IDX_W(14)) dut (
    .clk(clk), .reset(reset), .ms_bus(bus), .has_int(has_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_en(ws_fwd_en), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .csr_we(csr_we), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .idle_flush(idle_flush), .wb_pc(wb_pc), .wb_excp_num(wb_excp_num), .wb_badv(wb_badv),
    .idle_lock(idle_lock), .inst_retired(inst_retired)
  );

  typedef struct {
    logic [31:0] pc, result, va, csr_wdata;
    logic        gr_we, excp, ertn, refetch, idle, csr_we;
    logic [4:0]  dest;
    logic [15:0] excp_num;
    logic [13:0] csr_idx;
  } instr_t;

  // Model: the instruction sitting in writeback, whether the core is parked, retire count.
  instr_t      m_cur;
  bit          m_valid, m_parked;
  logic [63:0] m_cnt;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t blank();
    instr_t p;
    p = '{pc: 0, result: 0, va: 0, csr_wdata: 0, gr_we: 0, excp: 0, ertn: 0, refetch: 0,
          idle: 0, csr_we: 0, dest: 0, excp_num: 0, csr_idx: 0};
    return p;
  endfunction

  function automatic instr_t alu(input logic [4:0] d, input logic [31:0] v);
    instr_t p;
    p = blank();
    p.gr_we = 1'b1; p.dest = d; p.result = v; p.pc = 32'h1c00_0000 + {25'd0, d, 2'b00};
    return p;
  endfunction

  function automatic instr_t rand_instr();
    instr_t p;
    p.pc = $urandom; p.result = $urandom; p.va = $urandom; p.csr_wdata = $urandom;
    p.gr_we = ($urandom_range(0, 3) != 0);
    p.dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    p.excp = ($urandom_range(0, 9) == 0);
    p.excp_num = 16'(1) << $urandom_range(0, 15);
    p.ertn = ($urandom_range(0, 19) == 0);
    p.refetch = ($urandom_range(0, 19) == 0);
    p.idle = ($urandom_range(0, 24) == 0);
    p.csr_we = ($urandom_range(0, 4) == 0);
    p.csr_idx = 14'($urandom);
    return p;
  endfunction

  task automatic drive(input instr_t p, input bit v);
    bus.ms_to_ws_valid = v;
    bus.ms_pc = p.pc; bus.ms_result = p.result; bus.ms_gr_we = p.gr_we; bus.ms_dest = p.dest;
    bus.ms_excp = p.excp; bus.ms_excp_num = p.excp_num; bus.ms_error_va = p.va;
    bus.ms_ertn = p.ertn; bus.ms_refetch = p.refetch; bus.ms_idle = p.idle;
    bus.ms_csr_we = p.csr_we; bus.ms_csr_idx = p.csr_idx; bus.ms_csr_wdata = p.csr_wdata;
  endtask

  function automatic instr_t sample_in();
    instr_t p;
    p.pc = bus.ms_pc; p.result = bus.ms_result; p.gr_we = bus.ms_gr_we; p.dest = bus.ms_dest;
    p.excp = bus.ms_excp; p.excp_num = bus.ms_excp_num; p.va = bus.ms_error_va;
    p.ertn = bus.ms_ertn; p.refetch = bus.ms_refetch; p.idle = bus.ms_idle;
    p.csr_we = bus.ms_csr_we; p.csr_idx = bus.ms_csr_idx; p.csr_wdata = bus.ms_csr_wdata;
    return p;
  endfunction

  // Advance the model across one clock edge using the inputs presented before it.
  task automatic model_edge();
    instr_t incoming;
    bit in_valid, retires, flushing, open;
    incoming = sample_in();
    in_valid = bus.ms_to_ws_valid;
    if (reset) begin
      m_valid = 0; m_parked = 0; m_cnt = 0; m_cur = blank();
      return;
    end
    retires  = m_valid && !m_cur.excp;
    flushing = m_valid && (m_cur.excp || m_cur.ertn || m_cur.refetch || m_cur.idle);
    open     = !m_parked;
    if (retires) m_cnt = m_cnt + 64'd1;
    if (m_parked) begin
      if (has_int) m_parked = 0;
    end else if (retires && m_cur.idle) begin
      m_parked = 1;
    end
    if (in_valid && open) m_cur = incoming;
    if (flushing) m_valid = 0;
    else if (open) m_valid = in_valid;
  endtask

  task automatic compare();
    bit e_excp, e_ertn, e_ref, e_idle, e_rf, e_csr;
    e_excp = m_valid && m_cur.excp;
    e_ertn = m_valid && m_cur.ertn && !m_cur.excp;
    e_ref  = m_valid && m_cur.refetch && !m_cur.excp && !m_cur.ertn;
    e_idle = m_valid && m_cur.idle && !m_cur.excp;
    e_rf   = m_valid && m_cur.gr_we && !m_cur.excp && (m_cur.dest != 0);
    e_csr  = m_valid && m_cur.csr_we && !m_cur.excp;
    chk("allowin", bus.ws_allowin, !m_parked);
    chk("excp_flush", excp_flush, e_excp);
    chk("ertn_flush", ertn_flush, e_ertn);
    chk("refetch_flush", refetch_flush, e_ref);
    chk("idle_flush", idle_flush, e_idle);
    chk("rf_we", rf_we, e_rf);
    chk("fwd_en", ws_fwd_en, e_rf);
    chk("csr_we", csr_we, e_csr);
    chk("idle_lock", idle_lock, m_parked);
    chk("inst_retired", inst_retired, m_cnt);
    if (e_rf) begin
      chk("rf_waddr", rf_waddr, m_cur.dest);
      chk("rf_wdata", rf_wdata, m_cur.result);
    end
    if (m_valid) begin
      chk("fwd_dest", ws_fwd_dest, m_cur.dest);
      chk("fwd_data", ws_fwd_data, m_cur.result);
    end
    if (e_csr) begin
      chk("csr_idx", csr_idx, m_cur.csr_idx);
      chk("csr_wdata", csr_wdata, m_cur.csr_wdata);
    end
    if (e_excp) begin
      chk("wb_pc", wb_pc, m_cur.pc);
      chk("wb_excp_num", wb_excp_num, m_cur.excp_num);
      chk("wb_badv", wb_badv, m_cur.va);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    instr_t p;
    m_cur = blank(); m_valid = 0; m_parked = 0; m_cnt = 0;
    reset = 1'b1; has_int = 1'b0;
    drive(blank(), 1'b0);
    step(); step();
    chk("rst_retired", inst_retired, 64'd0);
    chk("rst_idle_lock", idle_lock, 1'b0);
    chk("rst_allowin", bus.ws_allowin, 1'b1);
    reset = 1'b0;

    // back-to-back ALU writes
    drive(alu(5'd4, 32'h11), 1'b1); step();
    chk("t1_we0", rf_we, 1'b1); chk("t1_addr0", rf_waddr, 5'd4); chk("t1_data0", rf_wdata, 32'h11);
    drive(alu(5'd5, 32'h22), 1'b1); step();
    chk("t1_we1", rf_we, 1'b1); chk("t1_addr1", rf_waddr, 5'd5); chk("t1_data1", rf_wdata, 32'h22);
    chk("t1_allowin", bus.ws_allowin, 1'b1); chk("t1_cnt", inst_retired, 64'd1);

    // write to r0 is suppressed but still retires
    drive(alu(5'd0, 32'hDEAD), 1'b1); step();
    chk("t2_we", rf_we, 1'b0); chk("t2_fwd", ws_fwd_en, 1'b0); chk("t2_cnt", inst_retired, 64'd2);
    drive(blank(), 1'b0); step();
    chk("t2_cnt_after", inst_retired, 64'd3);

    // exception commit and discard of the following instruction
    p = alu(5'd3, 32'h33); p.excp = 1; p.excp_num = 16'h0040; p.csr_we = 1; p.pc = 32'h1c00_0100;
    drive(p, 1'b1); step();
    chk("t3_excp", excp_flush, 1'b1); chk("t3_pc", wb_pc, 32'h1c00_0100);
    chk("t3_num", wb_excp_num, 16'h0040); chk("t3_rf", rf_we, 1'b0); chk("t3_csr", csr_we, 1'b0);
    chk("t3_cnt", inst_retired, 64'd3);
    drive(alu(5'd6, 32'h66), 1'b1); step();
    chk("t3_pulse", excp_flush, 1'b0); chk("t3_drop", rf_we, 1'b0);
    drive(blank(), 1'b0); step();
    chk("t3_drop2", rf_we, 1'b0); chk("t3_cnt2", inst_retired, 64'd3);

    // exception dominates ertn and refetch
    p = blank(); p.excp = 1; p.ertn = 1; p.refetch = 1; p.excp_num = 16'h0001;
    drive(p, 1'b1); step();
    chk("t4_excp", excp_flush, 1'b1); chk("t4_ertn", ertn_flush, 1'b0);
    chk("t4_ref", refetch_flush, 1'b0);
    drive(blank(), 1'b0); step();
    chk("t4_pulse", excp_flush, 1'b0);

    // idle parking, released by interrupt
    p = blank(); p.idle = 1; p.pc = 32'h200;
    drive(p, 1'b1); step();
    chk("t5_iflush", idle_flush, 1'b1); chk("t5_cnt0", inst_retired, 64'd3);
    drive(alu(5'd7, 32'h77), 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_lock", idle_lock, 1'b1); chk("t5_allowin", bus.ws_allowin, 1'b0);
      chk("t5_iflush_gone", idle_flush, 1'b0);
    end
    chk("t5_cnt1", inst_retired, 64'd4);
    has_int = 1'b1; step();
    chk("t5_unlock", idle_lock, 1'b0); chk("t5_reopen", bus.ws_allowin, 1'b1);
    chk("t5_nocap", rf_we, 1'b0);
    has_int = 1'b0; step();
    chk("t5_cap", rf_we, 1'b1); chk("t5_addr", rf_waddr, 5'd7);
    drive(blank(), 1'b0); step();
    chk("t5_cnt2", inst_retired, 64'd5);

    // interrupt in the same cycle as idle commit still parks once
    drive(p, 1'b1); has_int = 1'b1; step();
    drive(blank(), 1'b0); step();
    chk("t5b_lock", idle_lock, 1'b1);
    step();
    chk("t5b_unlock", idle_lock, 1'b0);
    has_int = 1'b0;

    // reset while parked, then reset with a valid instruction held
    drive(p, 1'b1); step();
    drive(blank(), 1'b0); step();
    chk("t6_parked", idle_lock, 1'b1);
    reset = 1'b1; step();
    chk("t6_lock", idle_lock, 1'b0); chk("t6_cnt", inst_retired, 64'd0);
    chk("t6_rf", rf_we, 1'b0); chk("t6_csr", csr_we, 1'b0); chk("t6_excp", excp_flush, 1'b0);
    chk("t6_idle", idle_flush, 1'b0); chk("t6_pc", wb_pc, 32'd0); chk("t6_fwd", ws_fwd_data, 32'd0);
    reset = 1'b0;
    drive(alu(5'd9, 32'h99), 1'b1); step();
    chk("t6_we", rf_we, 1'b1);
    reset = 1'b1; step();
    chk("t6_we_rst", rf_we, 1'b0); chk("t6_fwd_rst", ws_fwd_en, 1'b0);
    chk("t6_cnt_rst", inst_retired, 64'd0);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      has_int = ($urandom_range(0, 5) == 0);
      drive(rand_instr(), $urandom_range(0, 9) < 7);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
